ext_fifo_egress_pacer: RTL and testbench

Rate-pacing egress stage between the external-SRAM FIFO's read side (`dataout`/`src_rdy_o`/`dst_rdy_i`) and the downstream consumer on the internal clock domain. It absorbs FIFO output in a two-entry skid buffer. It releases words no faster than one per `rate` cycles, producing the decimate-by-N read patterns the datapath must tolerate. Optional counters report words and frames delivered.

---
 rtl/ext_fifo_egress_pacer.sv | 111 +++++++++++
 tb/tb_ext_fifo_egress_pacer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_fifo_egress_pacer.sv
// Rate-pacing egress stage: a two-entry skid buffer on the ext_fifo read side that releases words at most one per `rate` cycles.
// Optional word/frame counters are built when EGRESS_PACER_STATS_EN is defined.
module ext_fifo_egress_pacer #(
    parameter int WIDTH   = 36,
    parameter int RATE_W  = 8,
    parameter int EOF_BIT = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_src_rdy,
    output logic              i_dst_rdy,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_src_rdy,
    input  logic              o_dst_rdy
`ifdef EGRESS_PACER_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [31:0]       word_count,
    output logic [15:0]       frame_count
`endif
);

    logic [WIDTH-1:0]  mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        occupancy;
    logic [1:0]        next_occupancy;
    logic              dst_rdy_q;
    logic              in_xfer;
    logic              out_xfer;
    logic [RATE_W-1:0] gap;
    logic [RATE_W-1:0] gap_load;
    logic              hold;

    assign in_xfer  = i_src_rdy & dst_rdy_q;
    assign out_xfer = o_src_rdy & o_dst_rdy;

    // An offered word stays offered until taken, even if enable drops meanwhile.
    assign o_src_rdy = hold | (enable & (occupancy != 2'd0) & (gap == '0));
    assign o_data    = mem[rd_ptr];
    assign i_dst_rdy = dst_rdy_q;

    assign gap_load = (rate == '0) ? '0 : rate - RATE_W'(1);

    // NOTE: every variable driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_occupancy = occupancy;
        if (in_xfer && !out_xfer) begin
            next_occupancy = occupancy + 2'd1;
        end else if (!in_xfer && out_xfer) begin
            next_occupancy = occupancy - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            dst_rdy_q <= 1'b0;
            gap       <= '0;
            hold      <= 1'b0;
        end else begin
            occupancy <= next_occupancy;
            dst_rdy_q <= (next_occupancy < 2'd2);
            hold      <= o_src_rdy & ~o_dst_rdy;
            if (in_xfer) begin
                wr_ptr <= ~wr_ptr;
            end
            if (out_xfer) begin
                rd_ptr <= ~rd_ptr;
                gap    <= gap_load;
            end else if (gap != '0) begin
                gap <= gap - RATE_W'(1);
            end
        end
    end

    // NOTE: the two storage entries are reset because o_data must read zero out of reset; a deeper memory would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (in_xfer) begin
            mem[wr_ptr] <= i_data;
        end
    end

`ifdef EGRESS_PACER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count  <= '0;
            frame_count <= '0;
        end else if (stats_clr) begin
            word_count  <= '0;
            frame_count <= '0;
        end else if (out_xfer) begin
            word_count <= word_count + 32'd1;
            if (o_data[EOF_BIT]) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ext_fifo_egress_pacer.sv
// Randomized bench for ext_fifo_egress_pacer against a cycle-count/queue reference model.
// Counter checks are included when EGRESS_PACER_STATS_EN is defined.
module tb_ext_fifo_egress_pacer;
    localparam int WIDTH   = 36;
    localparam int RATE_W  = 8;
    localparam int EOF_BIT = 33;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [RATE_W-1:0] rate;
    logic [WIDTH-1:0]  i_data;
    logic              i_src_rdy;
    logic              i_dst_rdy;
    logic [WIDTH-1:0]  o_data;
    logic              o_src_rdy;
    logic              o_dst_rdy;
    logic              clr;
`ifdef EGRESS_PACER_STATS_EN
    logic [31:0]       word_count;
    logic [15:0]       frame_count;
`endif

    always #5 clk = ~clk;

    ext_fifo_egress_pacer #(.WIDTH(WIDTH), .RATE_W(RATE_W), .EOF_BIT(EOF_BIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rate        (rate),
        .i_data      (i_data),
        .i_src_rdy   (i_src_rdy),
        .i_dst_rdy   (i_dst_rdy),
        .o_data      (o_data),
        .o_src_rdy   (o_src_rdy),
        .o_dst_rdy   (o_dst_rdy)
`ifdef EGRESS_PACER_STATS_EN
        ,
        .stats_clr   (clr),
        .word_count  (word_count),
        .frame_count (frame_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue, pacing as "earliest edge allowed".
    logic [WIDTH-1:0] mq[$];
    int unsigned cyc, next_ok, sent;
    bit          held, rdy_valid, exp_src, exp_dst;
    int unsigned m_words;
    logic [15:0] m_frames;

    // Stimulus knobs
    int unsigned k_limit = 0;
    int          k_src_pct = 100, k_dst_pct = 100, k_en_pct = 100, k_clr_pct = 0;
    int          k_rate_min = 1, k_rate_max = 1;
    bit          k_eof = 1'b0;
    int unsigned eof_base = 0;

    // Transfers observed on the DUT pins
    bit          rec = 1'b0;
    int unsigned xfer_edges[$];
    int unsigned dut_out = 0;
    int unsigned dst_toggles = 0;
    bit          last_dst = 1'b0;

    function automatic logic [WIDTH-1:0] make_word(input int unsigned idx);
        logic [WIDTH-1:0] w;
        w = WIDTH'(idx);
        if (k_eof && idx > eof_base && ((idx - eof_base) % 1500) == 0) w[EOF_BIT] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        cyc = 0; next_ok = 0; held = 0; rdy_valid = 0;
        m_words = 0; m_frames = '0;
    endtask

    task automatic tick();
        bit in_x, out_x;
        @(negedge clk);
        i_src_rdy = (sent < k_limit) && ($urandom_range(99) < k_src_pct);
        i_data    = make_word(sent + 1);
        o_dst_rdy = $urandom_range(99) < k_dst_pct;
        enable    = $urandom_range(99) < k_en_pct;
        rate      = RATE_W'($urandom_range(k_rate_max, k_rate_min));
        clr       = $urandom_range(99) < k_clr_pct;
        #1;
        exp_dst = rdy_valid && (mq.size() < 2);
        exp_src = held || (enable && mq.size() > 0 && cyc >= next_ok);
        check("i_dst_rdy", i_dst_rdy, exp_dst);
        check("o_src_rdy", o_src_rdy, exp_src);
        if (exp_src) check("o_data", o_data, mq[0]);
`ifdef EGRESS_PACER_STATS_EN
        check("word_count", word_count, m_words);
        check("frame_count", frame_count, m_frames);
`endif
        if (o_src_rdy && o_dst_rdy) begin
            dut_out++;
            if (rec) xfer_edges.push_back(cyc);
        end
        if (i_dst_rdy != last_dst) dst_toggles++;
        last_dst = i_dst_rdy;
        @(posedge clk);
        out_x = exp_src && o_dst_rdy;
        in_x  = i_src_rdy && exp_dst;
        held  = exp_src && !o_dst_rdy;
        if (clr) begin
            m_words = 0; m_frames = '0;
        end else if (out_x) begin
            m_words++;
            if (mq[0][EOF_BIT]) m_frames++;
        end
        if (out_x) begin
            void'(mq.pop_front());
            next_ok = cyc + ((rate == 0) ? 1 : int'(rate));
        end
        if (in_x) begin
            mq.push_back(i_data);
            sent++;
        end
        rdy_valid = 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_o_src_rdy", o_src_rdy, 1'b0);
        check("rst_i_dst_rdy", i_dst_rdy, 1'b0);
        check("rst_o_data", o_data, '0);
`ifdef EGRESS_PACER_STATS_EN
        check("rst_word_count", word_count, 32'd0);
        check("rst_frame_count", frame_count, 16'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((sent < k_limit || mq.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_done", (sent == k_limit && mq.size() == 0), 1'b1);
    endtask

    task automatic set_rate(input int r);
        k_rate_min = r; k_rate_max = r;
    endtask

    initial begin
        int unsigned base_out;
        rst_n = 1'b0; enable = 1'b0; rate = '0; i_data = '0;
        i_src_rdy = 1'b0; o_dst_rdy = 1'b0; clr = 1'b0;
        sent = 0;
        model_reset();
        do_reset();

        // Stream 1..16 at full rate
        set_rate(1); k_limit = 16; base_out = dut_out;
        drain(200);
        check("p1_delivered", dut_out - base_out, 16);

        // rate=16, 2000 words, exact spacing
        set_rate(16); k_limit = sent + 2000; base_out = dut_out;
        rec = 1'b1; xfer_edges.delete(); dst_toggles = 0;
        drain(2000 * 16 + 100);
        rec = 1'b0;
        check("p2_delivered", dut_out - base_out, 2000);
        check("p2_dst_toggles", dst_toggles > 10, 1'b1);
        for (int i = 1; i < xfer_edges.size(); i++)
            check("p2_spacing", xfer_edges[i] - xfer_edges[i-1], 16);

        // Backpressure 20 cycles
        set_rate(1); k_limit = sent + 10; k_dst_pct = 0;
        repeat (20) tick();
        check("p3_held_src", o_src_rdy, 1'b1);
        check("p3_full", i_dst_rdy, 1'b0);
        k_dst_pct = 100; base_out = dut_out;
        drain(200);
        check("p3_delivered", dut_out - base_out, 10);

        // rate 16 -> 4 mid-gap
        set_rate(16); k_limit = sent + 40; rec = 1'b1; xfer_edges.delete();
        for (int n = 0; n < 100 && xfer_edges.size() == 0; n++) tick();
        repeat (5) tick();
        set_rate(4);
        drain(400);
        rec = 1'b0;
        check("p4_edges", xfer_edges.size() > 3, 1'b1);
        for (int i = 1; i < xfer_edges.size(); i++)
            check("p4_spacing", xfer_edges[i] - xfer_edges[i-1], (i == 1) ? 16 : 4);

        // enable=0 with input available
        set_rate(1); k_limit = sent + 8; k_en_pct = 0;
        repeat (10) tick();
        check("p5_no_output", o_src_rdy, 1'b0);
        check("p5_full", i_dst_rdy, 1'b0);
        k_en_pct = 100; base_out = dut_out;
        drain(100);
        check("p5_delivered", dut_out - base_out, 8);

        // Random mix
        k_rate_min = 0; k_rate_max = 5; k_src_pct = 70; k_dst_pct = 70; k_en_pct = 80; k_clr_pct = 5;
        k_limit = sent + 100000;
        repeat (4000) tick();
        k_limit = sent; k_en_pct = 100; k_dst_pct = 100; k_clr_pct = 0; set_rate(1);
        drain(200);

        // Three 1500-word frames, counters cleared first
        k_clr_pct = 100; tick(); k_clr_pct = 0;
        k_eof = 1'b1; eof_base = sent; k_src_pct = 100; k_limit = sent + 4500;
        drain(6000);
        tick();
`ifdef EGRESS_PACER_STATS_EN
        check("p7_word_count", word_count, 32'd4500);
        check("p7_frame_count", frame_count, 16'd3);
        k_clr_pct = 100; tick(); k_clr_pct = 0;
        tick();
        check("p7_clr_words", word_count, 32'd0);
        check("p7_clr_frames", frame_count, 16'd0);
`endif
        k_eof = 1'b0;

        // Reset mid-stream
        set_rate(2); k_limit = sent + 1000;
        repeat (30) tick();
        do_reset();
        k_limit = sent + 20;
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
